// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Memory stage: req/ack data-memory access with store lane steering
//            and load extraction/extension. Optional macro: UNALIGNED_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ExValid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUOut,
    input  logic        Overflow,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        RdValid,
    output logic [31:0] ReadData,
    output logic        AddrError,
    output logic        BusError,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemBe,
    output logic [31:0] DMemWData,
    input  logic        DMemAck,
    input  logic [31:0] DMemRData
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;

    // Counter only needs to reach TIMEOUT-1 before the abort fires
    localparam int             c_cw       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cw-1:0] c_tmo_last = c_cw'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [1:0]      r_off;
    logic [1:0]      r_size;
    logic            r_signed;
    logic            r_rd_valid;
    logic [31:0]     r_rdata;
    logic            r_bus_err;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;

    logic            w_accept;
    logic [1:0]      w_eff_off;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_ld_data;
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;

    assign w_accept = (r_state == c_st_idle) & ExValid & (MemRead | MemWrite) & ~Overflow;
    assign Stall    = w_accept | (r_state == c_st_req);

`ifdef UNALIGNED_TRAP_EN
    logic w_misaligned;
    logic r_addr_err;
    assign w_misaligned = ((MemSize == c_sz_half) & ALUOut[0]) |
                          (MemSize[1] & (ALUOut[1:0] != 2'b00));
    assign AddrError    = r_addr_err;
`else
    assign AddrError    = 1'b0;
`endif

    // Store lane steering; misaligned offsets are rounded down to alignment
    always_comb begin
        w_eff_off = 2'b00;
        w_be      = 4'b1111;
        w_wdata   = WriteData;
        case (MemSize)
            c_sz_byte: begin
                w_eff_off = ALUOut[1:0];
                w_be      = 4'b0001 << ALUOut[1:0];
                w_wdata   = {4{WriteData[7:0]}};
            end
            c_sz_half: begin
                w_eff_off = {ALUOut[1], 1'b0};
                w_be      = ALUOut[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{WriteData[15:0]}};
            end
            default: begin
                w_eff_off = 2'b00;
                w_be      = 4'b1111;
                w_wdata   = WriteData;
            end
        endcase
    end

    // Load lane extraction uses the offset/size captured at accept
    always_comb begin
        w_ld_byte = DMemRData[{r_off, 3'b000} +: 8];
        w_ld_half = r_off[1] ? DMemRData[31:16] : DMemRData[15:0];
        case (r_size)
            c_sz_byte: w_ld_data = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
            c_sz_half: w_ld_data = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
            default:   w_ld_data = DMemRData;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rdata    <= 32'h0;
            r_bus_err  <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= RESET_ADDR;
            r_be       <= 4'b0000;
            r_wdata    <= 32'h0;
`ifdef UNALIGNED_TRAP_EN
            r_addr_err <= 1'b0;
`endif
        end else begin
            r_rd_valid <= 1'b0;
            r_bus_err  <= 1'b0;
`ifdef UNALIGNED_TRAP_EN
            r_addr_err <= 1'b0;
`endif
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_off    <= w_eff_off;
                        r_size   <= MemSize;
                        r_signed <= MemSigned;
                        r_cnt    <= '0;
`ifdef UNALIGNED_TRAP_EN
                        if (w_misaligned) begin
                            r_addr_err <= 1'b1;
                            r_state    <= c_st_done;
                        end else
`endif
                        begin
                            r_req   <= 1'b1;
                            r_we    <= MemWrite;
                            r_addr  <= {ALUOut[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_state <= c_st_req;
                        end
                    end
                end
                c_st_req: begin
                    if (DMemAck) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_st_done;
                        if (!r_we) begin
                            r_rd_valid <= 1'b1;
                            r_rdata    <= w_ld_data;
                        end
                    end else if ((TIMEOUT > 0) && (r_cnt == c_tmo_last)) begin
                        r_req     <= 1'b0;
                        r_cnt     <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= c_st_done;
                    end else if (TIMEOUT > 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_we    <= 1'b0;
                    r_addr  <= RESET_ADDR;
                    r_be    <= 4'b0000;
                    r_wdata <= 32'h0;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign RdValid   = r_rd_valid;
    assign ReadData  = r_rdata;
    assign BusError  = r_bus_err;
    assign DMemReq   = r_req;
    assign DMemWe    = r_we;
    assign DMemAddr  = r_addr;
    assign DMemBe    = r_be;
    assign DMemWData = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ExValid, MemRead, MemWrite, MemSigned, Overflow;
    logic [1:0]  MemSize;
    logic [31:0] ALUOut, WriteData;
    logic        Stall, RdValid, AddrError, BusError;
    logic [31:0] ReadData;
    logic        DMemReq, DMemWe, DMemAck;
    logic [31:0] DMemAddr, DMemWData, DMemRData;
    logic [3:0]  DMemBe;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] c_raddr = 32'h0000_1000;

    mem_access_unit #(.TIMEOUT(4), .RESET_ADDR(c_raddr)) dut (
        .clk(clk), .reset(reset), .ExValid(ExValid), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .ALUOut(ALUOut), .Overflow(Overflow), .WriteData(WriteData),
        .Stall(Stall), .RdValid(RdValid), .ReadData(ReadData),
        .AddrError(AddrError), .BusError(BusError), .DMemReq(DMemReq),
        .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBe(DMemBe),
        .DMemWData(DMemWData), .DMemAck(DMemAck), .DMemRData(DMemRData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        ExValid = 1'b1; MemRead = rd; MemWrite = wr; MemSize = sz;
        MemSigned = sgn; ALUOut = addr; WriteData = wd; Overflow = 1'b0;
    endtask

    task automatic idle_in;
        ExValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Overflow = 1'b0;
    endtask

    // Single-wait-free load: accept, REQ with ack, then DONE result check
    task automatic load_fast(input string tag, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
        issue(1'b1, 1'b0, sz, sgn, addr, 32'h0);
        #1 chk({tag, "_stall_acc"}, {31'h0, Stall}, 32'h1);
        tick;
        idle_in;
        chk({tag, "_req"}, {31'h0, DMemReq}, 32'h1);
        chk({tag, "_addr"}, DMemAddr, exp_addr);
        chk({tag, "_we"}, {31'h0, DMemWe}, 32'h0);
        chk({tag, "_stall_req"}, {31'h0, Stall}, 32'h1);
        DMemAck = 1'b1; DMemRData = rdata;
        tick;
        DMemAck = 1'b0;
        chk({tag, "_rdvalid"}, {31'h0, RdValid}, 32'h1);
        chk({tag, "_rdata"}, ReadData, exp_data);
        chk({tag, "_req_drop"}, {31'h0, DMemReq}, 32'h0);
        chk({tag, "_stall_done"}, {31'h0, Stall}, 32'h0);
        tick;
        chk({tag, "_rdvalid_clr"}, {31'h0, RdValid}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; DMemAck = 1'b0; DMemRData = 32'h0;
        ExValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00;
        MemSigned = 1'b0; ALUOut = 32'h0; WriteData = 32'h0; Overflow = 1'b0;
        #2;
        chk("rst_req", {31'h0, DMemReq}, 32'h0);
        chk("rst_addr", DMemAddr, c_raddr);
        chk("rst_stall", {31'h0, Stall}, 32'h0);
        chk("rst_rdvalid", {31'h0, RdValid}, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_be", {28'h0, DMemBe}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Word load, ack in first REQ cycle
        load_fast("wload", 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h100, 32'hDEAD_BEEF);
        chk("wload_be_idle", {28'h0, DMemBe}, 32'h0);
        // Byte loads at top lane, signed and unsigned
        load_fast("sbyte", 2'b00, 1'b1, 32'h103, 32'h8011_2233, 32'h100, 32'hFFFF_FF80);
        load_fast("ubyte", 2'b00, 1'b0, 32'h103, 32'h8011_2233, 32'h100, 32'h0000_0080);
        load_fast("shalf", 2'b01, 1'b1, 32'h202, 32'h8001_7FFF, 32'h200, 32'hFFFF_8001);
        load_fast("uhalf", 2'b01, 1'b0, 32'h200, 32'h8001_9FFF, 32'h200, 32'h0000_9FFF);

        // Half store with three wait cycles
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h206, 32'h0000_ABCD);
        #1 chk("hst_stall_acc", {31'h0, Stall}, 32'h1);
        tick;
        idle_in;
        for (int i = 0; i < 4; i++) begin
            chk("hst_req", {31'h0, DMemReq}, 32'h1);
            chk("hst_addr", DMemAddr, 32'h204);
            chk("hst_be", {28'h0, DMemBe}, 32'hC);
            chk("hst_wdata", DMemWData, 32'hABCD_ABCD);
            chk("hst_we", {31'h0, DMemWe}, 32'h1);
            chk("hst_stall", {31'h0, Stall}, 32'h1);
            if (i == 3) DMemAck = 1'b1;
            tick;
        end
        DMemAck = 1'b0;
        chk("hst_rdvalid", {31'h0, RdValid}, 32'h0);
        chk("hst_req_drop", {31'h0, DMemReq}, 32'h0);
        chk("hst_rdata_hold", ReadData, 32'h0000_9FFF);
        tick;

        // Byte store lane steering
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h1234_5677);
        tick;
        idle_in;
        chk("bst_be", {28'h0, DMemBe}, 32'h2);
        chk("bst_wdata", DMemWData, 32'h7777_7777);
        DMemAck = 1'b1;
        tick;
        DMemAck = 1'b0;
        tick;

        // Overflow suppresses the access
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h5555_5555);
        Overflow = 1'b1;
        #1 chk("ovf_stall", {31'h0, Stall}, 32'h0);
        tick;
        idle_in;
        chk("ovf_req", {31'h0, DMemReq}, 32'h0);
        chk("ovf_addr", DMemAddr, c_raddr);

        // Timeout after four unacknowledged REQ cycles
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        tick;
        idle_in;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", {31'h0, DMemReq}, 32'h1);
            chk("tmo_buserr_low", {31'h0, BusError}, 32'h0);
            tick;
        end
        chk("tmo_req_drop", {31'h0, DMemReq}, 32'h0);
        chk("tmo_buserr", {31'h0, BusError}, 32'h1);
        chk("tmo_rdvalid", {31'h0, RdValid}, 32'h0);
        chk("tmo_rdata_hold", ReadData, 32'h0000_9FFF);
        chk("tmo_stall_done", {31'h0, Stall}, 32'h0);
        tick;
        chk("tmo_buserr_clr", {31'h0, BusError}, 32'h0);
        chk("tmo_idle_addr", DMemAddr, c_raddr);

        // Misaligned word load
`ifdef UNALIGNED_TRAP_EN
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        #1 chk("mis_stall_acc", {31'h0, Stall}, 32'h1);
        tick;
        idle_in;
        chk("mis_req", {31'h0, DMemReq}, 32'h0);
        chk("mis_addrerr", {31'h0, AddrError}, 32'h1);
        chk("mis_rdvalid", {31'h0, RdValid}, 32'h0);
        tick;
        chk("mis_addrerr_clr", {31'h0, AddrError}, 32'h0);
`else
        load_fast("mis", 2'b10, 1'b0, 32'h102, 32'h1234_5678, 32'h100, 32'h1234_5678);
        chk("mis_addrerr", {31'h0, AddrError}, 32'h0);
`endif

        // Reset during REQ; late ack must be ignored
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        tick;
        idle_in;
        chk("rmid_req_pre", {31'h0, DMemReq}, 32'h1);
        #2 reset = 1'b1;
        #1 chk("rmid_req_async", {31'h0, DMemReq}, 32'h0);
        chk("rmid_addr", DMemAddr, c_raddr);
        DMemAck = 1'b1; DMemRData = 32'hCAFE_F00D;
        @(negedge clk);
        reset = 1'b0;
        tick;
        chk("rmid_rdvalid", {31'h0, RdValid}, 32'h0);
        chk("rmid_req", {31'h0, DMemReq}, 32'h0);
        chk("rmid_stall", {31'h0, Stall}, 32'h0);
        tick;
        chk("rmid_rdvalid2", {31'h0, RdValid}, 32'h0);
        chk("rmid_rdata", ReadData, 32'h0);
        DMemAck = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
